// File: rtl/layer_sequencer.sv
// layer_sequencer: clear / fetch / drain / LUT-wait sequencer for one fully-connected MLP layer.
// Optional LUT-enable watchdog is built when LAYER_SEQ_TIMEOUT_EN is defined.
module layer_sequencer #(
    parameter int ADDR_W  = 16,
    parameter int MEM_LAT = 1
`ifdef LAYER_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 15
`endif
) (
    input  logic              pi_clk,
    input  logic              pi_rst_n,
    input  logic              pi_start,
    input  logic [ADDR_W-1:0] pi_num_inputs,
    input  logic              pi_hold,
    input  logic              pi_bram_en,
    output logic              po_mem_en,
    output logic [ADDR_W-1:0] po_mem_addr,
    output logic              po_clc_accumulator,
    output logic              po_valid,
    output logic              po_accumulation_done,
    output logic              po_busy,
    output logic              po_done,
    output logic              po_err
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CLEAR    = 3'd1,
        S_FETCH    = 3'd2,
        S_DRAIN    = 3'd3,
        S_DONE_ACC = 3'd4,
        S_WAIT_LUT = 3'd5,
        S_FINISH   = 3'd6,
        S_ERROR    = 3'd7
    } state_t;

    state_t             state_r;
    state_t             state_nx;
    logic [ADDR_W-1:0]  n_r;
    logic [ADDR_W-1:0]  cnt_r;
    logic [2:0]         dcnt_r;
    logic [MEM_LAT-1:0] vpipe_r;
    logic               mem_en_s;
    logic               last_issue_s;
    logic               drain_last_s;

    // Read issue: only in FETCH and only while the memory is not stalling us.
    always_comb begin
        mem_en_s = 1'b0;
        if ((state_r == S_FETCH) && !pi_hold) begin
            mem_en_s = 1'b1;
        end else begin
            mem_en_s = 1'b0;
        end
    end

    assign last_issue_s = mem_en_s && (cnt_r == (n_r - ADDR_W'(1)));
    // DRAIN lasts exactly MEM_LAT cycles, so the final valid has left the pipe when it ends.
    assign drain_last_s = (dcnt_r == 3'(MEM_LAT - 1));

    assign po_mem_en   = mem_en_s;
    assign po_mem_addr = (state_r == S_FETCH) ? cnt_r : {ADDR_W{1'b0}};
    assign po_valid    = vpipe_r[MEM_LAT-1];

`ifdef LAYER_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_r;
    logic            wd_expire_s;

    assign wd_expire_s = (wd_r == WD_W'(TIMEOUT - 1));

    // Watchdog counts cycles spent in WAIT_LUT; cleared everywhere else.
    always_ff @(posedge pi_clk or negedge pi_rst_n) begin
        if (!pi_rst_n) begin
            wd_r <= {WD_W{1'b0}};
        end else if (state_r == S_WAIT_LUT) begin
            wd_r <= wd_r + WD_W'(1);
        end else begin
            wd_r <= {WD_W{1'b0}};
        end
    end

    // Error pulse register, high during the single ERROR cycle.
    always_ff @(posedge pi_clk or negedge pi_rst_n) begin
        if (!pi_rst_n) begin
            po_err <= 1'b0;
        end else begin
            po_err <= (state_nx == S_ERROR);
        end
    end
`else
    assign po_err = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            S_IDLE: begin
                if (pi_start) begin
                    state_nx = S_CLEAR;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_CLEAR: begin
                if (n_r == {ADDR_W{1'b0}}) begin
                    state_nx = S_DRAIN;
                end else begin
                    state_nx = S_FETCH;
                end
            end
            S_FETCH: begin
                if (last_issue_s) begin
                    state_nx = S_DRAIN;
                end else begin
                    state_nx = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (drain_last_s) begin
                    state_nx = S_DONE_ACC;
                end else begin
                    state_nx = S_DRAIN;
                end
            end
            S_DONE_ACC: state_nx = S_WAIT_LUT;
            S_WAIT_LUT: begin
                if (pi_bram_en) begin
                    state_nx = S_FINISH;
                end
`ifdef LAYER_SEQ_TIMEOUT_EN
                else if (wd_expire_s) begin
                    state_nx = S_ERROR;
                end
`endif
                else begin
                    state_nx = S_WAIT_LUT;
                end
            end
            S_FINISH: state_nx = S_IDLE;
            S_ERROR:  state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge pi_clk or negedge pi_rst_n) begin
        if (!pi_rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Input count is captured only on an accepted start, so later changes are ignored.
    always_ff @(posedge pi_clk or negedge pi_rst_n) begin
        if (!pi_rst_n) begin
            n_r <= {ADDR_W{1'b0}};
        end else if ((state_r == S_IDLE) && pi_start) begin
            n_r <= pi_num_inputs;
        end else begin
            n_r <= n_r;
        end
    end

    // Address counter: zeroed outside a layer, advances on every issued read.
    always_ff @(posedge pi_clk or negedge pi_rst_n) begin
        if (!pi_rst_n) begin
            cnt_r <= {ADDR_W{1'b0}};
        end else if ((state_r == S_IDLE) || (state_r == S_CLEAR)) begin
            cnt_r <= {ADDR_W{1'b0}};
        end else if (mem_en_s) begin
            cnt_r <= cnt_r + ADDR_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Drain cycle counter.
    always_ff @(posedge pi_clk or negedge pi_rst_n) begin
        if (!pi_rst_n) begin
            dcnt_r <= 3'd0;
        end else if (state_r == S_DRAIN) begin
            dcnt_r <= dcnt_r + 3'd1;
        end else begin
            dcnt_r <= 3'd0;
        end
    end

    // Valid pipeline mirrors memory latency and keeps shifting through holds.
    always_ff @(posedge pi_clk or negedge pi_rst_n) begin
        if (!pi_rst_n) begin
            vpipe_r <= {MEM_LAT{1'b0}};
        end else begin
            vpipe_r <= (vpipe_r << 1) | MEM_LAT'(mem_en_s);
        end
    end

    // Control strobes registered from the next state so they line up with it.
    always_ff @(posedge pi_clk or negedge pi_rst_n) begin
        if (!pi_rst_n) begin
            po_clc_accumulator   <= 1'b0;
            po_accumulation_done <= 1'b0;
            po_busy              <= 1'b0;
            po_done              <= 1'b0;
        end else begin
            po_clc_accumulator   <= (state_nx == S_CLEAR);
            po_accumulation_done <= (state_nx == S_DONE_ACC);
            po_busy              <= (state_nx != S_IDLE);
            po_done              <= (state_nx == S_FINISH);
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: two instances (MEM_LAT=1 and MEM_LAT=2) share stimulus,
// per-cycle output bitmasks are compared against hand-computed values.
module tb_layer_sequencer;

    logic        pi_clk;
    logic        pi_rst_n;
    logic        pi_start;
    logic [15:0] pi_num_inputs;
    logic        pi_hold;
    logic        pi_bram_en;

    logic [1:0]  mem_en;
    logic [15:0] mem_addr [2];
    logic [1:0]  clc;
    logic [1:0]  valid;
    logic [1:0]  acc;
    logic [1:0]  busy;
    logic [1:0]  done;
    logic [1:0]  err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] en_m [2];
    logic [63:0] val_m [2];
    logic [63:0] clc_m [2];
    logic [63:0] acc_m [2];
    logic [63:0] done_m [2];
    logic [63:0] busy_m [2];
    logic [63:0] err_m [2];
    logic [63:0] addr_seq [2];

    layer_sequencer #(.ADDR_W(16), .MEM_LAT(1)) dut (
        .pi_clk(pi_clk), .pi_rst_n(pi_rst_n), .pi_start(pi_start),
        .pi_num_inputs(pi_num_inputs), .pi_hold(pi_hold), .pi_bram_en(pi_bram_en),
        .po_mem_en(mem_en[0]), .po_mem_addr(mem_addr[0]), .po_clc_accumulator(clc[0]),
        .po_valid(valid[0]), .po_accumulation_done(acc[0]), .po_busy(busy[0]),
        .po_done(done[0]), .po_err(err[0])
    );

    layer_sequencer #(.ADDR_W(16), .MEM_LAT(2)) dut2 (
        .pi_clk(pi_clk), .pi_rst_n(pi_rst_n), .pi_start(pi_start),
        .pi_num_inputs(pi_num_inputs), .pi_hold(pi_hold), .pi_bram_en(pi_bram_en),
        .po_mem_en(mem_en[1]), .po_mem_addr(mem_addr[1]), .po_clc_accumulator(clc[1]),
        .po_valid(valid[1]), .po_accumulation_done(acc[1]), .po_busy(busy[1]),
        .po_done(done[1]), .po_err(err[1])
    );

    initial pi_clk = 1'b0;
    always #5 pi_clk = ~pi_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] outs(input int i);
        return 64'({mem_en[i], mem_addr[i], clc[i], valid[i], acc[i], busy[i], done[i], err[i]});
    endfunction

    // Called at posedge+1 of cycle 0; bit k of each mask is the stimulus/response in cycle k.
    task automatic run_layer(input logic [15:0] n, input logic [63:0] hold_m,
                             input logic [63:0] bram_m, input logic [63:0] start_m, input int ncyc);
        for (int i = 0; i < 2; i++) begin
            en_m[i] = 64'd0; val_m[i] = 64'd0; clc_m[i] = 64'd0; acc_m[i] = 64'd0;
            done_m[i] = 64'd0; busy_m[i] = 64'd0; err_m[i] = 64'd0; addr_seq[i] = 64'd0;
        end
        for (int k = 0; k < ncyc; k++) begin
            pi_start      = start_m[k];
            pi_hold       = hold_m[k];
            pi_bram_en    = bram_m[k];
            pi_num_inputs = (k == 0) ? n : 16'd7;
            @(negedge pi_clk);
            for (int i = 0; i < 2; i++) begin
                en_m[i][k]   = mem_en[i];
                val_m[i][k]  = valid[i];
                clc_m[i][k]  = clc[i];
                acc_m[i][k]  = acc[i];
                done_m[i][k] = done[i];
                busy_m[i][k] = busy[i];
                err_m[i][k]  = err[i];
                if (mem_en[i]) begin
                    addr_seq[i] = {addr_seq[i][59:0], mem_addr[i][3:0]};
                end
            end
            @(posedge pi_clk);
            #1;
        end
        pi_start   = 1'b0;
        pi_hold    = 1'b0;
        pi_bram_en = 1'b0;
    endtask

    task automatic check_run(input string name, input int i, input logic [63:0] e_clc,
                             input logic [63:0] e_en, input logic [63:0] e_val, input logic [63:0] e_acc,
                             input logic [63:0] e_done, input logic [63:0] e_busy);
        check($sformatf("%s.clc%0d", name, i), clc_m[i], e_clc);
        check($sformatf("%s.en%0d", name, i), en_m[i], e_en);
        check($sformatf("%s.valid%0d", name, i), val_m[i], e_val);
        check($sformatf("%s.accdone%0d", name, i), acc_m[i], e_acc);
        check($sformatf("%s.done%0d", name, i), done_m[i], e_done);
        check($sformatf("%s.busy%0d", name, i), busy_m[i], e_busy);
    endtask

    // N=4, bram_en in cycles 8 and 9 (LAT1 takes 8, LAT2 ignores 8 in DONE_ACC and takes 9).
    task automatic check_basic(input string name);
        check_run(name, 0, 64'h2, 64'h3C, 64'h78, 64'h80, 64'h200, 64'h3FE);
        check_run(name, 1, 64'h2, 64'h3C, 64'hF0, 64'h100, 64'h400, 64'h7FE);
        check({name, ".addr0"}, addr_seq[0], 64'h0123);
        check({name, ".addr1"}, addr_seq[1], 64'h0123);
    endtask

    initial begin
        pi_rst_n      = 1'b0;
        pi_start      = 1'b0;
        pi_hold       = 1'b0;
        pi_bram_en    = 1'b0;
        pi_num_inputs = 16'd0;
        #2;
        check("reset.outs0", outs(0), 64'd0);
        check("reset.outs1", outs(1), 64'd0);
        @(negedge pi_clk);
        pi_rst_n = 1'b1;
        @(posedge pi_clk);
        #1;

        run_layer(16'd4, 64'h0, 64'h300, 64'h1, 12);
        check_basic("basic");

        run_layer(16'd3, 64'h8, 64'h200, 64'h1, 12);
        check_run("hold", 0, 64'h2, 64'h34, 64'h68, 64'h80, 64'h400, 64'h7FE);
        check_run("hold", 1, 64'h2, 64'h34, 64'hD0, 64'h100, 64'h400, 64'h7FE);
        check("hold.addr1", addr_seq[1], 64'h012);

        run_layer(16'd0, 64'h0, 64'h30, 64'h1, 8);
        check_run("zero", 0, 64'h2, 64'h0, 64'h0, 64'h8, 64'h20, 64'h3E);
        check_run("zero", 1, 64'h2, 64'h0, 64'h0, 64'h10, 64'h40, 64'h7E);

        run_layer(16'd4, 64'h0, 64'h300, 64'h209, 12);
        check_basic("busystart");

        run_layer(16'd2, 64'h0, 64'hC0, 64'h1, 10);
        check_run("after", 0, 64'h2, 64'hC, 64'h18, 64'h20, 64'h80, 64'hFE);
        check_run("after", 1, 64'h2, 64'hC, 64'h30, 64'h40, 64'h100, 64'h1FE);

        // Asynchronous reset in cycle 5 of an N=8 layer.
        pi_start      = 1'b1;
        pi_num_inputs = 16'd8;
        for (int k = 0; k < 5; k++) begin
            @(posedge pi_clk);
            #1;
            pi_start      = 1'b0;
            pi_num_inputs = 16'd7;
        end
        check("midrst.pre_en", 64'(mem_en), 64'h3);
        check("midrst.pre_addr", 64'(mem_addr[0]), 64'd3);
        #2;
        pi_rst_n = 1'b0;
        #1;
        check("midrst.outs0", outs(0), 64'd0);
        check("midrst.outs1", outs(1), 64'd0);
        @(posedge pi_clk);
        #2;
        pi_rst_n = 1'b1;
        @(posedge pi_clk);
        #1;
        run_layer(16'd0, 64'h0, 64'h0, 64'h0, 5);
        check("postrst.valid", val_m[0] | val_m[1], 64'd0);
        check("postrst.busy", busy_m[0] | busy_m[1], 64'd0);
        run_layer(16'd4, 64'h0, 64'h300, 64'h1, 12);
        check_basic("fresh");

        // LUT enable never arrives.
        run_layer(16'd1, 64'h0, 64'h0, 64'h1, 30);
        check("wd.accdone0", acc_m[0], 64'h10);
        check("wd.done0", done_m[0] | done_m[1], 64'd0);
`ifdef LAYER_SEQ_TIMEOUT_EN
        check("wd.err0", err_m[0], 64'h10_0000);
        check("wd.err1", err_m[1], 64'h20_0000);
        check("wd.busy0", busy_m[0], 64'h1F_FFFE);
        check("wd.busy1", busy_m[1], 64'h3F_FFFE);
        run_layer(16'd0, 64'h0, 64'h1, 64'h0, 4);
        check("wd.lateben", done_m[0] | done_m[1], 64'd0);
`else
        check("wd.err", err_m[0] | err_m[1], 64'd0);
        check("wd.busy0", busy_m[0], 64'h3FFF_FFFE);
        check("wd.busy1", busy_m[1], 64'h3FFF_FFFE);
        run_layer(16'd0, 64'h0, 64'h1, 64'h0, 4);
        check("wd.release0", done_m[0], 64'h2);
        check("wd.release1", done_m[1], 64'h2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
